// File: rtl/fx_to_ft_pkg.sv
// Shared constants and types for the Q2.22 fixed-point to IEEE-754 single converter.
// The float layout struct matches the float-to-fixed block's view of the same word.
package fx_ft_pkg;

    localparam int unsigned FX_W     = 24;
    localparam int unsigned FRAC_W   = 22;
    localparam int unsigned FT_BIAS  = 127;
    // Biased exponent of the top magnitude bit: (FX_W-1) - FRAC_W + FT_BIAS.
    localparam int unsigned EXP_INIT = FX_W - 1 - FRAC_W + FT_BIAS;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } ft_t;

endpackage

// File: rtl/fx_to_ft_if.sv
// Nios II multi-cycle custom-instruction handshake between the CPU side and the converter.
interface fx_to_ft_if;

    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    modport master (
        output clk_en,
        output start,
        output dataa,
        input  done,
        input  result
    );

    modport slave (
        input  clk_en,
        input  start,
        input  dataa,
        output done,
        output result
    );

endinterface

// File: rtl/fx_to_ft.sv
// Serial Q2.22 fixed-point to IEEE-754 single converter: one normalising shift per cycle.
// Conversion is exact, so there is no rounding step.
module fx_to_ft
    import fx_ft_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    fx_to_ft_if.slave  bus
);

    state_t            r_state;
    logic              r_sign;
    logic [FX_W-1:0]   r_mag;
    logic [7:0]        r_exp;
    logic              r_zero;
    logic              r_done;
    logic [31:0]       r_result;

    logic [FX_W-1:0]   w_fx;
    logic [FX_W-1:0]   w_abs;
    ft_t               w_packed;
    logic              w_unused;

    assign w_fx     = bus.dataa[FX_W-1:0];
    assign w_unused = ^bus.dataa[31:FX_W];

    // The most negative input negates to itself, which is the correct unsigned magnitude.
    assign w_abs = w_fx[FX_W-1] ? -w_fx : w_fx;

    always_comb begin
        w_packed      = '0;
        w_packed.sign = r_sign;
        w_packed.exp  = r_exp;
        w_packed.mant = 23'(r_mag[FX_W-2:0]) << (24 - FX_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_exp    <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (bus.clk_en) begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign  <= w_fx[FX_W-1];
                        r_mag   <= w_abs;
                        r_exp   <= 8'(EXP_INIT);
                        r_zero  <= 1'b0;
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (r_mag == '0) begin
                        r_zero  <= 1'b1;
                        r_state <= PACK;
                    end else if (r_mag[FX_W-1]) begin
                        r_state <= PACK;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                PACK: begin
                    r_result <= r_zero ? '0 : w_packed;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_fx_to_ft.sv
// Bench for fx_to_ft: directed vector table, clk_en stall / reset-abort sequences,
// and random operands checked against a real-arithmetic reference and a float-to-fixed round trip.
module tb_fx_to_ft;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fx_to_ft_if bus();

    fx_to_ft dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] f;
        int          lat;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = x / 2^22 computed in real arithmetic, then repacked from the double encoding.
    function automatic void ref_model(input logic [31:0] d, output logic [31:0] f, output int lat);
        logic [23:0] v;
        int          x;
        real         r;
        logic [63:0] b;
        int          e;
        v = d[23:0];
        x = int'($signed(v));
        if (x == 0) begin
            f   = 32'h0;
            lat = 2;
        end else begin
            r   = real'(x) / 4194304.0;
            b   = $realtobits(r);
            e   = int'(b[62:52]) - 1023;
            f   = {b[63], 8'(e + 127), b[51:29]};
            lat = 3 - e;
        end
    endfunction

    // Independent float-to-fixed conversion for the round-trip check.
    function automatic logic [23:0] ft_to_fx(input logic [31:0] f);
        logic [63:0] b;
        real         r;
        if (f[30:0] == 31'h0) return 24'h0;
        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
        r = $bitstoreal(b) * 4194304.0;
        return 24'($rtoi(r));
    endfunction

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = -1;
        for (int k = 1; k <= limit && !ok; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ok  = 1'b1;
                cyc = k;
            end
        end
    endtask

    task automatic run_conv(input logic [31:0] d, output logic [31:0] res, output int cyc);
        bit ok;
        @(negedge clk);
        bus.dataa = d;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(60, cyc, ok);
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no done for dataa=%h within 60 cycles", d);
        end
        res = bus.result;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp_f;
        int          cyc;
        int          exp_lat;
        int          extra;
        bit          got;
        logic [31:0] d;

        tbl[0] = '{32'h0040_0000, 32'h3F80_0000, 3};
        tbl[1] = '{32'h0080_0000, 32'hC000_0000, 2};
        tbl[2] = '{32'h0000_0001, 32'h3480_0000, 25};
        tbl[3] = '{32'h00E0_0000, 32'hBF00_0000, 4};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 2};
        tbl[5] = '{32'h0060_0000, 32'h3FC0_0000, 3};
        tbl[6] = '{32'hFF40_0000, 32'h3F80_0000, 3};
        tbl[7] = '{32'h007F_FFFF, 32'h3FFF_FFFE, 3};
        tbl[8] = '{32'h00FF_FFFF, 32'hB480_0000, 25};
        tbl[9] = '{32'hAB00_0000, 32'h0000_0000, 2};

        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.dataa  = 32'h0;
        reset      = 1'b1;
        #23;
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_result", bus.result, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_conv(tbl[i].d, res, cyc);
            check($sformatf("tbl%0d_result", i), res, tbl[i].f);
            check($sformatf("tbl%0d_latency", i), 32'(cyc), 32'(tbl[i].lat));
        end

        // clk_en stall mid-NORM plus an ignored start during the conversion.
        @(negedge clk);
        bus.dataa = 32'h0000_0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        got = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 80 && !got; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                got = 1'b1;
                cyc = k;
            end else begin
                if (k == 5)  bus.clk_en = 1'b0;
                if (k == 10) bus.clk_en = 1'b1;
                if (k == 12) begin
                    bus.dataa = 32'h0040_0000;
                    bus.start = 1'b1;
                end
                if (k == 13) bus.start = 1'b0;
            end
        end
        check("stall_latency", 32'(cyc), 32'd30);
        check("stall_result", bus.result, 32'h3480_0000);
        bus.clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stretch_done", 32'(bus.done), 32'h1);
        bus.clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("stretch_release", 32'(bus.done), 32'h0);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        check("no_queued_start", 32'(extra), 32'h0);
        check("result_held", bus.result, 32'h3480_0000);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        bus.dataa = 32'h0000_0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_result", bus.result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        check("abort_no_done", 32'(extra), 32'h0);
        run_conv(32'h0040_0000, res, cyc);
        check("post_reset_result", res, 32'h3F80_0000);
        check("post_reset_latency", 32'(cyc), 32'd3);

        // Random operands, with a share of small magnitudes to reach deep normalisation.
        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            if (i % 3 == 0) d = d >> $urandom_range(8, 31);
            ref_model(d, exp_f, exp_lat);
            run_conv(d, res, cyc);
            check($sformatf("rand%0d_result d=%h", i, d), res, exp_f);
            check($sformatf("rand%0d_latency d=%h", i, d), 32'(cyc), 32'(exp_lat));
            check($sformatf("rand%0d_roundtrip d=%h", i, d), 32'(ft_to_fx(res)), 32'(d[23:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fx_to_ft.md
Name: fx_to_ft

Overview:
- Multi-cycle converter from 24-bit two's-complement fixed point to IEEE-754 single precision.
- It is the inverse of the team's float-to-fixed block and uses the same fixed-point format: Q2.22, value = x / 2^22, range [-2.0, 2.0).
- Wrapped as a Nios II multi-cycle custom instruction (start/done handshake, clk_en gating).
- Normalises serially, one shift per cycle. Conversion is exact, so no rounding stage exists.

Parameters:
- FX_W, 24, fixed-point input width including sign bit.
- FRAC_W, 22, number of fractional bits in the input.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- clk_en, input, 1, all state and register updates occur only when high; low freezes the block.
- start, input, 1, request strobe; sampled only in IDLE with clk_en high.
- dataa, input, 32, bits [23:0] hold the fixed-point operand; bits [31:24] are ignored.
- done, output, 1, registered, one-cycle pulse when result is valid.
- result, output, 32, registered IEEE-754 single; held until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE, done=0, result=32'h0, internal registers cleared.
- Reset asserted mid-conversion aborts it; no done pulse for the aborted operation.
- States:
  - IDLE: on start && clk_en, capture sign = dataa[23] and mag = |dataa[23:0]| as a 24-bit unsigned value. 0x800000 gives mag = 0x800000, which fits. Set exp = 128 and go to NORM.
  - NORM: if mag == 0, go to PACK with a zero flag. Else if mag[23] == 1, go to PACK. Else shift mag left by 1, decrement exp, stay in NORM.
  - PACK: result = {sign, exp[7:0], mag[22:0]}; the zero flag forces result = 32'h00000000, i.e. +0.0. Assert done for this cycle only and return to IDLE.
- Exponent rule: leading-one position p (0..23) gives biased exponent p + 105, i.e. p - FRAC_W + 127. The range is 105..128; no overflow, underflow or denormals.
- Mantissa: bits below the leading one, left-aligned into 23 bits. This is exact because at most 23 bits lie below the leading one.
- Latency: start sampled at edge N gives done high after edge N + (23 - p) + 2. Zero input gives done at N+2.
- start while not in IDLE is ignored; no queueing.
- done may fall and start may be re-asserted in the same cycle. The new start is accepted one cycle after done, once the state is IDLE.
- clk_en low in any state holds state, counters, done and result unchanged. A done pulse stretches while clk_en is low.
- result changes only in PACK; it is stable between conversions.

Decomposition:
- Package fx_ft_pkg:
  - FX_W, FRAC_W, FT_BIAS = 127, EXP_INIT = 128.
  - State enum {IDLE, NORM, PACK}.
  - Typedef for the 32-bit float field layout (sign/exp/mant struct).
- No sub-module: the absolute value and the serial normaliser are small enough to sit inline in one always_ff/always_comb pair.

Test Plan:
- dataa = 0x400000 (1.0) -> result 0x3F800000, done at N+3.
- dataa = 0x800000 (-2.0) -> result 0xC0000000, done at N+2.
- dataa = 0x000001 (2^-22) -> result 0x34800000, done at N+25. Then dataa = 0xE00000 (-0.5) -> result 0xBF000000, done at N+4.
- dataa = 0x000000 -> result 0x00000000, done at N+2. Then 0x600000 (1.5) -> 0x3FC00000.
- Start 0x000001, hold clk_en low for 5 cycles mid-NORM -> done at N+30 with 0x34800000. Re-pulse start mid-conversion -> ignored, single done.
- Assert reset at N+10 of a 0x000001 conversion -> done=0 and result=0 immediately; next start 0x400000 gives 0x3F800000 at +3. Random round-trip through the float-to-fixed block returns the original 24-bit value.
